gfx_fb_writer: RTL

GFX_FB_WRITER -- requirements
Module: gfx_fb_writer

---
 rtl/gfx_fb_writer.sv | 105 ++++++++++
 1 files changed

// File: rtl/gfx_fb_writer.sv
// Pixel-stream to framebuffer write adapter: a 2-entry FIFO of {addr, color, last}
// with out-of-bounds filtering and per-frame completion tracking.
module gfx_fb_writer #(
  parameter int unsigned VGA_WIDTH  = 640,
  parameter int unsigned VGA_HEIGHT = 480,
  parameter int unsigned COLOR_BITS = 12,
  localparam int unsigned X_BITS    = $clog2(VGA_WIDTH),
  localparam int unsigned Y_BITS    = $clog2(VGA_HEIGHT),
  localparam int unsigned ADDR_BITS = $clog2(VGA_WIDTH * VGA_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [X_BITS-1:0]     s_x,
  input  logic [Y_BITS-1:0]     s_y,
  input  logic [COLOR_BITS-1:0] s_color,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_BITS-1:0]  m_addr,
  output logic [COLOR_BITS-1:0] m_data,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_oob
);

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [COLOR_BITS-1:0] color;
    logic                  last;
  } entry_t;

  // head_q is the output slot; skid_q holds the second entry when full
  entry_t      head_q, skid_q, head_next, skid_next, in_entry;
  logic [1:0]  count_q, count_next;
  logic        ready_q, valid_q, done_q, oob_q, pend_q;
  logic [15:0] fcount_q;

  logic accept, in_bounds, push, pop, oob_accept, pend_next, done_next;

  always_comb begin
    accept     = s_valid && ready_q;
    in_bounds  = (32'(s_x) < VGA_WIDTH) && (32'(s_y) < VGA_HEIGHT);
    push       = accept && in_bounds;
    oob_accept = accept && !in_bounds;
    pop        = valid_q && m_ready;

    in_entry.addr  = ADDR_BITS'(32'(s_y) * VGA_WIDTH + 32'(s_x));
    in_entry.color = s_color;
    in_entry.last  = s_last;

    head_next  = head_q;
    skid_next  = skid_q;
    count_next = count_q + 2'(push) - 2'(pop);

    case (count_q)
      2'd0: if (push) head_next = in_entry;
      2'd1: begin
        if (push && pop) head_next = in_entry;
        else if (push)   skid_next = in_entry;
      end
      default: if (pop) head_next = skid_q;
    endcase

    // An out-of-bounds last pixel completes its frame once the FIFO has drained;
    // input is stalled meanwhile so later pixels cannot delay that point.
    pend_next = (pend_q || (oob_accept && s_last)) && (count_next != 2'd0);
    done_next = (pop && head_q.last) ||
                ((pend_q || (oob_accept && s_last)) && (count_next == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      skid_q   <= '0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      pend_q   <= 1'b0;
      fcount_q <= 16'd0;
    end else begin
      head_q   <= head_next;
      skid_q   <= skid_next;
      count_q  <= count_next;
      ready_q  <= (count_next != 2'd2) && !pend_next;
      valid_q  <= (count_next != 2'd0);
      done_q   <= done_next;
      oob_q    <= oob_q || oob_accept;
      pend_q   <= pend_next;
      fcount_q <= fcount_q + 16'(done_next);
    end
  end

  assign s_ready     = ready_q;
  assign m_valid     = valid_q;
  assign m_addr      = head_q.addr;
  assign m_data      = head_q.color;
  assign frame_done  = done_q;
  assign frame_count = fcount_q;
  assign err_oob     = oob_q;

endmodule
